// File: rtl/column_source_pkg.sv
// Shared types for the column source: the default pixel and column types,
// the FSM state encoding, and a width helper for counter sizing.
package column_source_pkg;

  localparam int LUMA_BITS_DEF     = 8;
  localparam int WINDOW_SIZE_Y_DEF = 5;

  typedef logic [LUMA_BITS_DEF-1:0] luma_t;
  typedef luma_t [WINDOW_SIZE_Y_DEF-1:0] column_t;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  // Counter width for n distinct values; never returns zero.
  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/column_index_fifo.sv
// Shift register of the most recent valid column indices. Entry 0 is the
// newest; the last entry is the oldest and is only meaningful when full.
module column_index_fifo
  import column_source_pkg::*;
#(
  parameter int DEPTH      = 7,
  parameter int INDEX_BITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  push,
  input  logic [INDEX_BITS-1:0] push_index,
  output logic                  full,
  output logic [INDEX_BITS-1:0] oldest
);

  localparam int CNT_W = safe_clog2(DEPTH + 1);

  logic [INDEX_BITS-1:0] entry_reg [DEPTH];
  logic [CNT_W-1:0]      count_reg;

  // Occupancy count, saturating once the window is full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (push && !full) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      // Each stage takes the new index (stage 0) or its younger neighbour.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          entry_reg[gi] <= '0;
        end else if (clear) begin
          entry_reg[gi] <= '0;
        end else if (push) begin
          if (gi == 0) begin
            entry_reg[gi] <= push_index;
          end else begin
            entry_reg[gi] <= entry_reg[(gi > 0) ? gi - 1 : 0];
          end
        end
      end
    end
  endgenerate

  assign full   = (count_reg == CNT_W'(DEPTH));
  assign oldest = entry_reg[DEPTH-1];

endmodule

// File: rtl/column_source.sv
// Buffers one strip of WINDOW_SIZE_Y rows in raster order, then replays it
// column by column together with a "peek" column: the WINDOW_SIZE_X-th most
// recent valid column before the current one.
module column_source
  import column_source_pkg::*;
#(
  parameter int LUMA_BITS     = 8,
  parameter int WINDOW_SIZE_X = 7,
  parameter int WINDOW_SIZE_Y = 5,
  parameter int IMAGE_WIDTH   = 26
) (
  input  logic                                    clk,
  input  logic                                    in_reset,
  input  logic [LUMA_BITS-1:0]                    in_pixel,
  input  logic                                    in_pixel_valid,
  input  logic                                    in_col_skip,
  output logic                                    out_ready,
  output logic [WINDOW_SIZE_Y-1:0][LUMA_BITS-1:0] out_column,
  output logic [WINDOW_SIZE_Y-1:0][LUMA_BITS-1:0] out_peek_column,
  output logic                                    out_valid,
  output logic                                    out_reset
);

  localparam int COL_W = safe_clog2(IMAGE_WIDTH);
  localparam int ROW_W = safe_clog2(WINDOW_SIZE_Y);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMAGE_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(WINDOW_SIZE_Y - 1);

  state_t                 state_reg;
  logic [ROW_W-1:0]       row_reg;
  logic [COL_W-1:0]       col_reg;
  logic [COL_W-1:0]       emit_reg;
  logic [IMAGE_WIDTH-1:0] skip_reg;
  logic                   ready_reg;
  logic                   valid_reg;
  logic                   first_reg;

  logic                   accept;
  logic                   last_pixel;
  logic                   sel_en;
  logic [COL_W-1:0]       sel_col;
  logic                   sel_valid;
  logic                   fifo_push;
  logic                   fifo_clear;
  logic                   fifo_full;
  logic [COL_W-1:0]       fifo_oldest;

  assign accept     = ready_reg && in_pixel_valid;
  assign last_pixel = (row_reg == LAST_ROW) && (col_reg == LAST_COL);

  // Column selected at this edge for presentation in the next cycle.
  always_comb begin
    sel_en  = 1'b0;
    sel_col = '0;
    if (state_reg == ST_FILL) begin
      sel_en  = accept && last_pixel;
      sel_col = '0;
    end else begin
      sel_en  = (emit_reg != LAST_COL);
      sel_col = emit_reg + 1'b1;
    end
  end

  assign sel_valid  = ~skip_reg[sel_col];
  assign fifo_push  = sel_en && sel_valid;
  assign fifo_clear = (state_reg == ST_EMIT) && (emit_reg == LAST_COL);

  // Control FSM: raster counters and skip capture in FILL, column replay in EMIT.
  always_ff @(posedge clk or posedge in_reset) begin
    if (in_reset) begin
      state_reg <= ST_FILL;
      row_reg   <= '0;
      col_reg   <= '0;
      emit_reg  <= '0;
      skip_reg  <= '0;
      ready_reg <= 1'b1;
      valid_reg <= 1'b0;
      first_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_FILL: begin
          valid_reg <= 1'b0;
          first_reg <= 1'b0;
          if (accept) begin
            if (row_reg == '0) begin
              skip_reg[col_reg] <= in_col_skip;
            end
            if (last_pixel) begin
              state_reg <= ST_EMIT;
              ready_reg <= 1'b0;
              row_reg   <= '0;
              col_reg   <= '0;
              emit_reg  <= '0;
              valid_reg <= sel_valid;
              first_reg <= 1'b1;
            end else if (col_reg == LAST_COL) begin
              col_reg <= '0;
              row_reg <= row_reg + 1'b1;
            end else begin
              col_reg <= col_reg + 1'b1;
            end
          end
        end
        ST_EMIT: begin
          first_reg <= 1'b0;
          if (emit_reg == LAST_COL) begin
            state_reg <= ST_FILL;
            ready_reg <= 1'b1;
            valid_reg <= 1'b0;
            skip_reg  <= '0;
          end else begin
            emit_reg  <= emit_reg + 1'b1;
            valid_reg <= sel_valid;
          end
        end
        default: begin
          state_reg <= ST_FILL;
          ready_reg <= 1'b1;
        end
      endcase
    end
  end

  column_index_fifo #(
    .DEPTH      (WINDOW_SIZE_X),
    .INDEX_BITS (COL_W)
  ) u_index_fifo (
    .clk        (clk),
    .rst        (in_reset),
    .clear      (fifo_clear),
    .push       (fifo_push),
    .push_index (sel_col),
    .full       (fifo_full),
    .oldest     (fifo_oldest)
  );

  genvar gi;
  generate
    for (gi = 0; gi < WINDOW_SIZE_Y; gi++) begin : g_row
      logic [LUMA_BITS-1:0] mem [IMAGE_WIDTH];
      logic [LUMA_BITS-1:0] cur_reg;
      logic [LUMA_BITS-1:0] peek_reg;

      // Strip buffer row: written only while this row is being filled.
      always_ff @(posedge clk) begin
        if (accept && (row_reg == ROW_W'(gi))) begin
          mem[col_reg] <= in_pixel;
        end
      end

      // Registered current and peek reads; zero whenever nothing is presented.
      always_ff @(posedge clk or posedge in_reset) begin
        if (in_reset) begin
          cur_reg  <= '0;
          peek_reg <= '0;
        end else begin
          cur_reg  <= sel_en ? mem[sel_col] : '0;
          peek_reg <= (sel_en && fifo_full) ? mem[fifo_oldest] : '0;
        end
      end

      assign out_column[gi]      = cur_reg;
      assign out_peek_column[gi] = peek_reg;
    end
  endgenerate

  assign out_ready = ready_reg;
  assign out_valid = valid_reg;
  assign out_reset = first_reg;

endmodule

// File: tb/tb_column_source.sv
// Randomized bench for column_source with a strip-level reference model.
module tb_column_source;

  localparam int LB = 8;
  localparam int WX = 7;
  localparam int WY = 5;
  localparam int IW = 26;

  logic                   clk = 1'b0;
  logic                   in_reset;
  logic [LB-1:0]          in_pixel;
  logic                   in_pixel_valid;
  logic                   in_col_skip;
  logic                   out_ready;
  logic [WY-1:0][LB-1:0]  out_column;
  logic [WY-1:0][LB-1:0]  out_peek_column;
  logic                   out_valid;
  logic                   out_reset;

  column_source #(
    .LUMA_BITS     (LB),
    .WINDOW_SIZE_X (WX),
    .WINDOW_SIZE_Y (WY),
    .IMAGE_WIDTH   (IW)
  ) dut (
    .clk             (clk),
    .in_reset        (in_reset),
    .in_pixel        (in_pixel),
    .in_pixel_valid  (in_pixel_valid),
    .in_col_skip     (in_col_skip),
    .out_ready       (out_ready),
    .out_column      (out_column),
    .out_peek_column (out_peek_column),
    .out_valid       (out_valid),
    .out_reset       (out_reset)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference strip: pixel values and skip flags for the strip being sent.
  logic [LB-1:0] pix [WY][IW];
  bit            skp [IW];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Column k of the reference strip, row i in bits [i*LB +: LB].
  function automatic logic [63:0] col_of(input int k);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < WY; i++) v[i*LB +: LB] = pix[i][k];
    return v;
  endfunction

  // The WX-th most recent valid column strictly before k, else zero.
  function automatic logic [63:0] peek_of(input int k);
    int q[$];
    for (int j = 0; j < k; j++) if (!skp[j]) q.push_back(j);
    if (q.size() >= WX) return col_of(q[q.size() - WX]);
    return '0;
  endfunction

  task automatic fill_formula();
    for (int r = 0; r < WY; r++)
      for (int c = 0; c < IW; c++) pix[r][c] = LB'(r * IW + c + 1);
  endtask

  task automatic fill_random();
    for (int r = 0; r < WY; r++)
      for (int c = 0; c < IW; c++) pix[r][c] = LB'($urandom);
  endtask

  task automatic skips_none();
    for (int c = 0; c < IW; c++) skp[c] = 1'b0;
  endtask

  task automatic skips_random();
    for (int c = 0; c < IW; c++) skp[c] = ($urandom_range(0, 3) == 0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, 64'(out_ready), 64'd1);
    check({tag, "_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_reset"}, 64'(out_reset), 64'd0);
    check({tag, "_col"},   64'(out_column), 64'd0);
    check({tag, "_peek"},  64'(out_peek_column), 64'd0);
  endtask

  // Sends one strip (optionally with gapped valid) and checks every emitted
  // column. abort_at >= 0 pulses in_reset right after that column is checked.
  task automatic run_strip(input string name, input bit toggle, input int abort_at);
    int  accepts;
    int  guard;
    int  r;
    int  c;
    bit  rdy;
    accepts = 0;
    guard   = 0;
    while (accepts < WY * IW && guard < 4000) begin
      @(negedge clk);
      r = accepts / IW;
      c = accepts % IW;
      in_pixel       = pix[r][c];
      in_col_skip    = (r == 0) ? skp[c] : 1'($urandom);
      in_pixel_valid = toggle ? 1'($urandom) : 1'b1;
      rdy            = out_ready;
      @(posedge clk);
      if (rdy && in_pixel_valid) accepts++;
      guard++;
    end
    #1;
    in_pixel_valid = 1'b0;
    if (accepts < WY * IW) begin
      check({name, "_fill_timeout"}, 64'(accepts), 64'(WY * IW));
      return;
    end
    for (int k = 0; k < IW; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      $display("%s col %0d: valid=%0b reset=%0b col=%0h peek=%0h",
               name, k, out_valid, out_reset, out_column, out_peek_column);
      check($sformatf("%s_k%0d_ready", name, k), 64'(out_ready), 64'd0);
      check($sformatf("%s_k%0d_col", name, k), 64'(out_column), col_of(k));
      check($sformatf("%s_k%0d_peek", name, k), 64'(out_peek_column), peek_of(k));
      check($sformatf("%s_k%0d_valid", name, k), 64'(out_valid), 64'(!skp[k]));
      check($sformatf("%s_k%0d_reset", name, k), 64'(out_reset), 64'(k == 0));
      if (k == abort_at) begin
        in_reset = 1'b1;
        #1;
        check_idle({name, "_async_rst"});
        @(negedge clk);
        in_reset = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    check_idle({name, "_after_emit"});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    in_reset       = 1'b1;
    in_pixel       = '0;
    in_pixel_valid = 1'b0;
    in_col_skip    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    @(negedge clk);
    in_reset = 1'b0;

    // Formula strip with skips {3,7,11}: column data, valid, reset and peek.
    fill_formula();
    skips_none();
    skp[3] = 1'b1; skp[7] = 1'b1; skp[11] = 1'b1;
    run_strip("t1", 1'b0, -1);

    // No skips, random data: peek trails by exactly WX columns.
    fill_random();
    skips_none();
    run_strip("t3", 1'b0, -1);

    // Same as the formula strip but with gapped in_pixel_valid.
    fill_formula();
    skips_none();
    skp[3] = 1'b1; skp[7] = 1'b1; skp[11] = 1'b1;
    run_strip("t4", 1'b1, -1);

    // Reset in the middle of EMIT, then a complete strip from pixel (0,0).
    fill_random();
    skips_random();
    run_strip("t5a", 1'b0, 5);
    fill_random();
    skips_random();
    run_strip("t5b", 1'b0, -1);

    // Back-to-back strips with different random skip sets.
    for (int s = 0; s < 4; s++) begin
      fill_random();
      skips_random();
      run_strip($sformatf("t6_%0d", s), s[0], -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
